// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// Size encodings, per-size lane masks, FSM states, and the alignment predicate.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // An address is aligned when it is a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/data shift-left and load
// shift-right, truncate and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_off,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_sh;
  logic [63:0] w_rsh;
  logic [7:0]  w_size_mask;

  assign w_sh  = {i_off, 3'b000};
  assign w_rsh = i_rdata >> w_sh;

  always_comb begin
    w_size_mask = MASK_D;
    o_rdata     = w_rsh;
    case (i_size)
      SZ_B: begin
        w_size_mask = MASK_B;
        o_rdata = i_unsigned ? {56'd0, w_rsh[7:0]} : {{56{w_rsh[7]}}, w_rsh[7:0]};
      end
      SZ_H: begin
        w_size_mask = MASK_H;
        o_rdata = i_unsigned ? {48'd0, w_rsh[15:0]} : {{48{w_rsh[15]}}, w_rsh[15:0]};
      end
      SZ_W: begin
        w_size_mask = MASK_W;
        o_rdata = i_unsigned ? {32'd0, w_rsh[31:0]} : {{32{w_rsh[31]}}, w_rsh[31:0]};
      end
      default: begin
        w_size_mask = MASK_D;
        o_rdata     = w_rsh;
      end
    endcase
  end

  // Lanes pushed past byte 7 / bit 63 fall off the top of the 8/64-bit result.
  assign o_wmask = w_size_mask << i_off;
  assign o_wdata = i_wdata << w_sh;

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: IDLE -> [WAIT] -> ACCESS -> RESP.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned requests into error responses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        men,
  output logic        mwen,
  output logic [63:0] raddr,
  output logic [63:0] waddr,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  input  logic [63:0] rdata,
  output lsu_state_e  dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid && req_ready;
  // a response transfers on resp_valid && resp_ready, and resp_* are held
  // stable until then. Neither valid waits on its ready.

  lsu_state_e  r_state, w_next;
  logic [31:0] r_cnt;
  logic        r_wen, r_uns, r_mis;
  logic [1:0]  r_size;
  logic [63:0] r_addr, r_wdata, r_resp_rdata;
  logic        w_req_mis, w_wait_done, w_access;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata, w_load;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_mis = is_misaligned(req_size, req_addr[2:0]);
`else
  assign w_req_mis = 1'b0;
`endif

  assign w_wait_done = (r_cnt == 32'(WAIT_CYCLES - 1));
  assign w_access    = (r_state == ST_ACCESS);

  lsu_align u_align (
    .i_size     (r_size),
    .i_off      (r_addr[2:0]),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rdata    (rdata),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load)
  );

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    men           = 1'b0;
    mwen          = 1'b0;
    raddr         = '0;
    waddr         = '0;
    wdata         = '0;
    wmask         = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_mis)            w_next = ST_RESP;
          else if (WAIT_CYCLES > 0) w_next = ST_WAIT;
          else                      w_next = ST_ACCESS;
        end
      end
      ST_WAIT: if (w_wait_done) w_next = ST_ACCESS;
      ST_ACCESS: begin
        // Enables are gated by reset so a reset cycle never touches memory.
        men    = !rst;
        mwen   = r_wen && !rst;
        raddr  = {r_addr[63:3], 3'b000};
        waddr  = {r_addr[63:3], 3'b000};
        wdata  = w_wdata;
        wmask  = w_wmask;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_uns        <= 1'b0;
      r_mis        <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_wen   <= req_wen;
          r_uns   <= req_unsigned;
          r_size  <= req_size;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_mis   <= w_req_mis;
          r_cnt   <= '0;
          if (w_req_mis) r_resp_rdata <= '0;
        end
        ST_WAIT:   r_cnt <= r_cnt + 32'd1;
        ST_ACCESS: r_resp_rdata <= r_wen ? 64'd0 : w_load;
        default: ;
      endcase
    end
  end

  assign resp_rdata    = r_resp_rdata;
  assign resp_misalign = r_mis;
  assign dbg_state     = r_state;

endmodule
